btn_irq_ctrl: RTL and testbench
===============================

# btn_irq_ctrl

Parametrised push-button controller: synchronises and debounces NUM_BTN button inputs, latches per-channel edge events with configurable rising/falling sensitivity, and raises a single level interrupt. It sits on the same simple register bus (wr_*/rd_*) as the existing peripherals, next to the interrupt controller, and replaces the fixed 4-button sampler with a scalable, bounce-free, edge-selectable version.

## Interface
- NUM_BTN, 4, number of button channels (1..16)
- CLK_DIV, 1000000, sample period in clk cycles (>=2); 100 Hz at 100 MHz
- DEB_SAMPLES, 4, consecutive differing samples required to accept a new level (1..15)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_addr  in  4  write byte address; [3:2] selects register
- wr_en  in  1  write strobe, one cycle
- wr_data  in  32  write data
- wr_strb  in  4  byte enables; write accepted only when 4'b1111
- rd_addr  in  4  read byte address; [3:2] selects register
- rd_en  in  1  read strobe
- rd_data  out  32  read data, combinational
- btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed
- irq  out  1  level interrupt, |(IER & IFR)

## Operation
- Registers (unused bits read 0, writes to them ignored):
  - 0x0 STATUS, RO: [NUM_BTN-1:0] debounced levels. Writes ignored.
  - 0x4 IER, R/W: [NUM_BTN-1:0] interrupt enables.
  - 0x8 IFR, R/W1C: [NUM_BTN-1:0] event flags; writing 1 clears, 0 no effect.
  - 0xC EDGE_CFG, R/W: [NUM_BTN-1:0] rising-edge enable, [16+NUM_BTN-1:16] falling-edge enable.
- Reset values: STATUS 0, IER 0, IFR 0, EDGE_CFG rise bits all 1 / fall bits 0, debounce counters 0, synchronisers 0, divider CLK_DIV-1, irq 0, rd_data 0.
- Synchroniser: btn_in passes through a 2-FF synchroniser every clk cycle (sync).
- Tick: down-counter from CLK_DIV-1 to 0, reloads; tick = (counter == 0), one-cycle pulse every CLK_DIV cycles.
- Debounce per channel i on tick only:
  - sync[i] == deb[i]: cnt[i] <= 0.
  - sync[i] != deb[i] and cnt[i] < DEB_SAMPLES-1: cnt[i] increments.
  - sync[i] != deb[i] and cnt[i] == DEB_SAMPLES-1: deb[i] <= sync[i], cnt[i] <= 0, edge event (rise if new level 1, fall if 0).
- IFR[i] set on an edge event whose type is enabled in EDGE_CFG; set independent of IER. Set has priority over a same-cycle W1C clear.
- Reading IFR does not clear it. rd_data = 0 when rd_en low.

## Timing
- Register writes take effect on the clk edge with wr_en high; visible on reads from the next cycle.
- rd_data combinational from rd_en/rd_addr and current register state, same cycle.
- Input to debounced level: 2 cycles synchroniser + DEB_SAMPLES ticks; worst case 2 + DEB_SAMPLES*CLK_DIV cycles.
- STATUS and IFR update on the same clk edge (the tick edge accepting the level); irq rises one cycle later at most (combinational from registered IER/IFR, so same cycle as IFR).
- A pulse shorter than DEB_SAMPLES consecutive ticks causes no STATUS change and no flag.
- Changing EDGE_CFG or IER never sets or clears IFR; enabling IER with IFR already set asserts irq immediately.
- rst asserted at any time (including mid-debounce) clears all state immediately, without waiting for clk; first tick occurs CLK_DIV cycles after rst deasserts.

## Test plan
Bench: NUM_BTN=4, CLK_DIV=3, DEB_SAMPLES=3.
- Reset: read 0x0/0x4/0x8 -> 0, 0xC -> 0x0000000F, irq 0; assert rst mid-run -> same values without a clk edge.
- Hold btn_in=4'b0001: STATUS=0x1 and IFR=0x1 within 2+9 cycles; irq 0; write IER=0x1 -> irq 1; write IFR=0x1 -> IFR 0, irq 0.
- Bounce: btn1 high for 4 cycles (spanning 1-2 ticks) -> STATUS and IFR stay 0.
- EDGE_CFG=0x00040000: press btn2 -> STATUS=0x4, IFR 0; release -> STATUS 0, IFR=0x4.
- W1C of IFR bit0 on the same cycle btn0 edge sets it -> IFR bit0 remains 1.
- Write IER=0xF with wr_strb=4'b0011 -> IER stays 0; write to 0x0 -> STATUS unchanged.

Source files
------------

// File: rtl/btn_irq_ctrl.sv
// btn_irq_ctrl: synchronises and debounces NUM_BTN push buttons, latches
// per-channel rise/fall events into a W1C flag register and drives a single
// level interrupt from the enabled flags. Registers sit on the simple
// wr_*/rd_* peripheral bus:
//   0x0 STATUS   RO   debounced levels
//   0x4 IER      R/W  interrupt enables
//   0x8 IFR      W1C  event flags
//   0xC EDGE_CFG R/W  [NUM_BTN-1:0] rise enable, [16+NUM_BTN-1:16] fall enable
module btn_irq_ctrl #(
    parameter int NUM_BTN     = 4,
    parameter int CLK_DIV     = 1000000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         wr_addr,
    input  logic               wr_en,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_strb,
    input  logic [3:0]         rd_addr,
    input  logic               rd_en,
    output logic [31:0]        rd_data,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic               irq
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_SAMPLES - 1);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_IER    = 2'd1;
    localparam logic [1:0] REG_IFR    = 2'd2;
    localparam logic [1:0] REG_EDGE   = 2'd3;

    logic [NUM_BTN-1:0] sync_1;
    logic [NUM_BTN-1:0] sync_2;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_next;
    logic [CNT_W-1:0]   deb_cnt  [NUM_BTN];
    logic [CNT_W-1:0]   cnt_next [NUM_BTN];
    logic [NUM_BTN-1:0] rise_evt;
    logic [NUM_BTN-1:0] fall_evt;

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;

    logic [NUM_BTN-1:0] ier;
    logic [NUM_BTN-1:0] ifr;
    logic [NUM_BTN-1:0] rise_en;
    logic [NUM_BTN-1:0] fall_en;
    logic [NUM_BTN-1:0] ifr_set;
    logic [NUM_BTN-1:0] ifr_clr;
    logic               wr_ok;

    // Address low bits and upper data bits are don't-care on this bus.
    logic unused_bits;
    assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data};

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
        end
    end

    // Sample-period down-counter; tick is the cycle the counter sits at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= DIV_LOAD;
        end else if (tick) begin
            div_cnt <= DIV_LOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

    // Per-channel debounce: a new level is accepted after DEB_SAMPLES
    // consecutive differing tick samples; any agreeing sample restarts the run.
    always_comb begin
        deb_next = deb;
        rise_evt = '0;
        fall_evt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_next[i] = deb_cnt[i];
            if (tick) begin
                if (sync_2[i] == deb[i]) begin
                    cnt_next[i] = '0;
                end else if (deb_cnt[i] >= CNT_LAST) begin
                    deb_next[i] = sync_2[i];
                    cnt_next[i] = '0;
                    rise_evt[i] = sync_2[i];
                    fall_evt[i] = ~sync_2[i];
                end else begin
                    cnt_next[i] = deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level and run-length counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= cnt_next[i];
            end
        end
    end

    assign wr_ok   = wr_en && (wr_strb == 4'b1111);
    assign ifr_set = (rise_evt & rise_en) | (fall_evt & fall_en);
    assign ifr_clr = (wr_ok && (wr_addr[3:2] == REG_IFR)) ? wr_data[NUM_BTN-1:0] : '0;

    // Control registers; a flag set by an event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ier     <= '0;
            ifr     <= '0;
            rise_en <= '1;
            fall_en <= '0;
        end else begin
            ifr <= (ifr & ~ifr_clr) | ifr_set;
            if (wr_ok && (wr_addr[3:2] == REG_IER)) begin
                ier <= wr_data[NUM_BTN-1:0];
            end
            if (wr_ok && (wr_addr[3:2] == REG_EDGE)) begin
                rise_en <= wr_data[NUM_BTN-1:0];
                fall_en <= wr_data[16 +: NUM_BTN];
            end
        end
    end

    // Combinational read mux; idle bus reads zero.
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (rd_addr[3:2])
                REG_STATUS: rd_data[NUM_BTN-1:0] = deb;
                REG_IER:    rd_data[NUM_BTN-1:0] = ier;
                REG_IFR:    rd_data[NUM_BTN-1:0] = ifr;
                REG_EDGE: begin
                    rd_data[NUM_BTN-1:0]  = rise_en;
                    rd_data[16 +: NUM_BTN] = fall_en;
                end
                default:    rd_data = '0;
            endcase
        end
    end

    assign irq = |(ier & ifr);

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Self-checking bench for btn_irq_ctrl (NUM_BTN=4, CLK_DIV=3, DEB_SAMPLES=3).
module tb_btn_irq_ctrl;

    localparam int N   = 4;
    localparam int DIV = 3;
    localparam int DEB = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [N-1:0] btn_in;
    logic        irq;

    btn_irq_ctrl #(.NUM_BTN(N), .CLK_DIV(DIV), .DEB_SAMPLES(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .btn_in  (btn_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: tick = every DIV-th edge after reset, sync value is
    // btn_in from two edges earlier, a level is accepted when the last DEB tick
    // samples all disagree with the current debounced level.
    int         m_k;
    logic [3:0] m_h1, m_h2, m_deb, m_ier, m_ifr, m_rise, m_fall;
    logic [3:0] m_win [DEB];

    task automatic model_reset();
        m_k = 0;
        m_h1 = '0; m_h2 = '0; m_deb = '0; m_ier = '0; m_ifr = '0;
        m_rise = 4'hF; m_fall = '0;
        for (int j = 0; j < DEB; j++) m_win[j] = '0;
    endtask

    task automatic model_step();
        logic [3:0] sample, rev, fev, set_m, clr_m;
        bit all_diff;
        m_k++;
        sample = m_h2;
        m_h2 = m_h1;
        m_h1 = btn_in;
        rev = '0;
        fev = '0;
        if (m_k % DIV == 0) begin
            for (int j = DEB - 1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = sample;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (m_win[j][i] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[i] = ~m_deb[i];
                    if (m_deb[i]) rev[i] = 1'b1;
                    else          fev[i] = 1'b1;
                end
            end
        end
        set_m = (rev & m_rise) | (fev & m_fall);
        clr_m = '0;
        if (wr_en && wr_strb == 4'hF) begin
            case (wr_addr[3:2])
                2'd1: m_ier = wr_data[3:0];
                2'd2: clr_m = wr_data[3:0];
                2'd3: begin m_rise = wr_data[3:0]; m_fall = wr_data[19:16]; end
                default: ;
            endcase
        end
        m_ifr = (m_ifr & ~clr_m) | set_m;
    endtask

    function automatic logic [31:0] m_rd(input logic en, input logic [3:0] a);
        if (!en) return 32'h0;
        case (a[3:2])
            2'd0: return {28'h0, m_deb};
            2'd1: return {28'h0, m_ier};
            2'd2: return {28'h0, m_ifr};
            default: return {12'h0, m_fall, 12'h0, m_rise};
        endcase
    endfunction

    // One clock: model follows the edge, then outputs are compared after the
    // falling edge. Returns at negedge+1 so callers can drive new inputs.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        #1;
        check("model_irq", {31'h0, irq}, {31'h0, |(m_ier & m_ifr)});
        check("model_rd", rd_data, m_rd(rd_en, rd_addr));
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic expect_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
        cycle();
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        int found;

        vecs[0]  = '{4'h4, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'h4, 32'h0000_000F};
        vecs[1]  = '{4'h4, 32'h0000_0000, 4'h3, 1'b1, 4'h4, 32'h0000_000F};
        vecs[2]  = '{4'h4, 32'h0000_0000, 4'hF, 1'b1, 4'h4, 32'h0000_0000};
        vecs[3]  = '{4'h4, 32'h0000_000F, 4'h3, 1'b1, 4'h4, 32'h0000_0000};
        vecs[4]  = '{4'h0, 32'h0000_000F, 4'hF, 1'b1, 4'h0, 32'h0000_0000};
        vecs[5]  = '{4'hC, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'hC, 32'h000F_000F};
        vecs[6]  = '{4'hC, 32'h1234_5678, 4'hF, 1'b1, 4'hC, 32'h0004_0008};
        vecs[7]  = '{4'hC, 32'h0000_000F, 4'hF, 1'b0, 4'hC, 32'h0000_0000};
        vecs[8]  = '{4'hC, 32'h0000_000F, 4'hF, 1'b1, 4'hC, 32'h0000_000F};
        vecs[9]  = '{4'h8, 32'h0000_000F, 4'hF, 1'b1, 4'h8, 32'h0000_0000};
        vecs[10] = '{4'h5, 32'h0000_000A, 4'hF, 1'b1, 4'h4, 32'h0000_000A};
        vecs[11] = '{4'h4, 32'h0000_0000, 4'hF, 1'b1, 4'h6, 32'h0000_0000};

        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en = 1'b0; rd_addr = '0; btn_in = '0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        expect_reg("reset_status", 4'h0, 32'h0);
        expect_reg("reset_ier",    4'h4, 32'h0);
        expect_reg("reset_ifr",    4'h8, 32'h0);
        expect_reg("reset_edge",   4'hC, 32'h0000_000F);
        check("reset_irq", {31'h0, irq}, 32'h0);
        rd_en = 1'b0;
        #1;
        check("reset_rd_idle", rd_data, 32'h0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Register table
        for (int i = 0; i < 12; i++) begin
            wr(vecs[i].wa, vecs[i].wd, vecs[i].ws);
            rd_en = vecs[i].re;
            rd_addr = vecs[i].ra;
            #1;
            check($sformatf("vec%0d", i), rd_data, vecs[i].exp);
        end
        wr(4'h4, 32'h0, 4'hF);

        // Press btn0 and hold: accepted within 2 + DEB*DIV edges
        btn_in = 4'b0001;
        found = 0;
        for (int c = 0; c < 2 + DEB * DIV && found == 0; c++) begin
            cycle();
            rd(4'h0, d);
            if (d[0]) found = 1;
        end
        check("press_latency", found, 1);
        expect_reg("press_status", 4'h0, 32'h1);
        expect_reg("press_ifr",    4'h8, 32'h1);
        check("press_irq_masked", {31'h0, irq}, 32'h0);
        wr(4'h4, 32'h1, 4'hF);
        check("ier_irq_on", {31'h0, irq}, 32'h1);
        wr(4'h8, 32'h1, 4'hF);
        expect_reg("w1c_ifr", 4'h8, 32'h0);
        check("w1c_irq_off", {31'h0, irq}, 32'h0);

        // Release: falling edges disabled by default, no flag
        btn_in = 4'b0000;
        repeat (14) cycle();
        expect_reg("release_status", 4'h0, 32'h0);
        expect_reg("release_ifr",    4'h8, 32'h0);

        // Bounce: 4-cycle pulse on btn1 must be rejected
        btn_in = 4'b0010;
        repeat (4) cycle();
        btn_in = 4'b0000;
        repeat (14) cycle();
        expect_reg("bounce_status", 4'h0, 32'h0);
        expect_reg("bounce_ifr",    4'h8, 32'h0);

        // Fall-only sensitivity on btn2
        wr(4'hC, 32'h0004_0000, 4'hF);
        btn_in = 4'b0100;
        repeat (12) cycle();
        expect_reg("fall_press_status", 4'h0, 32'h4);
        expect_reg("fall_press_ifr",    4'h8, 32'h0);
        btn_in = 4'b0000;
        repeat (12) cycle();
        expect_reg("fall_rel_status", 4'h0, 32'h0);
        expect_reg("fall_rel_ifr",    4'h8, 32'h4);
        wr(4'h8, 32'h4, 4'hF);
        expect_reg("fall_clear", 4'h8, 32'h0);
        wr(4'hC, 32'h0000_000F, 4'hF);

        // Set beats a same-cycle W1C clear: keep clearing bit0 every cycle
        wr_en = 1'b1; wr_addr = 4'h8; wr_data = 32'h1; wr_strb = 4'hF;
        btn_in = 4'b0001;
        found = 0;
        for (int c = 0; c < 2 + DEB * DIV + 1 && found == 0; c++) begin
            cycle();
            rd(4'h0, d);
            if (d[0]) begin
                found = 1;
                rd(4'h8, d2);
                check("set_beats_clear", {31'h0, d2[0]}, 32'h1);
            end
        end
        check("collide_latency", found, 1);
        wr_en = 1'b0;
        cycle();
        expect_reg("collide_ifr_held", 4'h8, 32'h1);
        wr(4'h8, 32'hF, 4'hF);
        btn_in = 4'b0000;
        repeat (14) cycle();

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) btn_in = 4'($urandom_range(0, 15));
            wr_en = ($urandom_range(0, 5) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            rd_en = ($urandom_range(0, 3) != 0);
            rd_addr = 4'($urandom_range(0, 15));
            cycle();
        end
        wr_en = 1'b0;

        // Asynchronous reset mid-debounce
        wr(4'h4, 32'hF, 4'hF);
        wr(4'hC, 32'h000F_000F, 4'hF);
        btn_in = ~btn_in;
        repeat (4) cycle();
        rst = 1'b1;
        model_reset();
        #1;
        expect_reg("arst_status", 4'h0, 32'h0);
        expect_reg("arst_ier",    4'h4, 32'h0);
        expect_reg("arst_ifr",    4'h8, 32'h0);
        expect_reg("arst_edge",   4'hC, 32'h0000_000F);
        check("arst_irq", {31'h0, irq}, 32'h0);
        repeat (2) cycle();
        rst = 1'b0;
        btn_in = 4'hF;
        repeat (20) cycle();
        expect_reg("post_rst_status", 4'h0, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
